// File: rtl/mgmii_to_gmii_pkg.sv
// Shared encodings for the MII receive nibble-to-byte reassembler.
package mgmii_to_gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LO,
        ST_HI,
        ST_EOF,
        ST_DROP
    } rx_state_e;

    localparam logic [3:0] PRE_NIBBLE = 4'h5;
    localparam logic [3:0] SFD_NIBBLE = 4'hD;
    localparam logic [7:0] SFD_BYTE   = 8'hD5;

endpackage

// File: rtl/mgmii_to_gmii_if.sv
// Receive-path bundle: PHY-side nibble/byte stream in, MAC-side byte stream and frame status out.
interface mgmii_to_gmii_if #(
    parameter int unsigned LEN_W = 11
);
    logic [7:0]       rxd_in;
    logic             rxdv_in;
    logic             rxer_in;
    logic [7:0]       rxd_out;
    logic             rxdv_out;
    logic             rxer_out;
    logic             sof_out;
    logic             eof_out;
    logic [LEN_W-1:0] frame_len;
    logic             dribble_err;
    logic             long_err;
    logic             pre_err;

    // PHY / stimulus side
    modport master (
        output rxd_in, rxdv_in, rxer_in,
        input  rxd_out, rxdv_out, rxer_out, sof_out, eof_out,
        input  frame_len, dribble_err, long_err, pre_err
    );

    // Reassembler side
    modport slave (
        input  rxd_in, rxdv_in, rxer_in,
        output rxd_out, rxdv_out, rxer_out, sof_out, eof_out,
        output frame_len, dribble_err, long_err, pre_err
    );
endinterface

// File: rtl/mgmii_to_gmii_mii_rx_len_cnt.sv
// Saturating frame byte counter; loads 1 on the SFD byte and stops at MAX_LEN.
module mii_rx_len_cnt #(
    parameter int unsigned LEN_W   = 11,
    parameter int unsigned MAX_LEN = 1536
) (
    input  logic             clk_gmii_2x,
    input  logic             resetn_rx,
    input  logic             start,
    input  logic             inc,
    output logic [LEN_W-1:0] count,
    output logic             full,
    output logic             ovf
);
    logic [LEN_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Full at the length limit, or at all-ones so the counter can never wrap.
    assign full  = (count_q == LEN_W'(MAX_LEN)) || (&count_q);
    assign count = count_q;
    assign ovf   = ovf_q;

    // Next count: restart at SFD, advance on delivered bytes, flag bytes refused while full.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (start) begin
            count_d = LEN_W'(1);
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_gmii_2x or negedge resetn_rx) begin
        if (!resetn_rx) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: rtl/mgmii_to_gmii.sv
// MII receive reassembler: strips preamble, aligns on SFD, pairs nibbles into bytes; GMII mode is a registered bypass.
module mgmii_to_gmii #(
    parameter int unsigned LEN_W   = 11,
    parameter int unsigned MAX_LEN = 1536
) (
    input logic           clk_gmii_2x,
    input logic           resetn_rx,
    input logic           gmii_mode,
    mgmii_to_gmii_if.slave rx
);
    import mgmii_to_gmii_pkg::*;

    rx_state_e        state_q, state_d;
    logic [3:0]       lat_q, lat_d;
    logic             er_lat_q, er_lat_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             rxdv_q, rxdv_d;
    logic             rxer_q, rxer_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             drib_q, drib_d;
    logic             long_q, long_d;
    logic             pre_err_q, pre_err_d;

    logic             cnt_start, cnt_inc, cnt_full, cnt_ovf;
    logic [LEN_W-1:0] cnt;
    logic [3:0]       nib;

    assign nib = rx.rxd_in[3:0];

    mii_rx_len_cnt #(
        .LEN_W   (LEN_W),
        .MAX_LEN (MAX_LEN)
    ) u_len_cnt (
        .clk_gmii_2x (clk_gmii_2x),
        .resetn_rx   (resetn_rx),
        .start       (cnt_start),
        .inc         (cnt_inc),
        .count       (cnt),
        .full        (cnt_full),
        .ovf         (cnt_ovf)
    );

    // Next-state and next-output decode; EOF shares IDLE's evaluation so a back-to-back carrier is not lost.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        er_lat_d  = er_lat_q;
        rxd_d     = rxd_q;
        rxdv_d    = 1'b0;
        rxer_d    = 1'b0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        drib_d    = 1'b0;
        long_d    = 1'b0;
        pre_err_d = 1'b0;
        cnt_start = 1'b0;
        cnt_inc   = 1'b0;
        if (gmii_mode) begin
            state_d = ST_IDLE;
            rxd_d   = rx.rxd_in;
            rxdv_d  = rx.rxdv_in;
            rxer_d  = rx.rxer_in;
        end else begin
            case (state_q)
                ST_IDLE, ST_EOF: begin
                    if (!rx.rxdv_in) begin
                        state_d = ST_IDLE;
                    end else if (nib == PRE_NIBBLE) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d   = ST_DROP;
                        pre_err_d = 1'b1;
                    end
                end
                ST_PRE: begin
                    if (!rx.rxdv_in) begin
                        state_d = ST_IDLE;
                    end else if (rx.rxer_in) begin
                        state_d   = ST_DROP;
                        pre_err_d = 1'b1;
                    end else if (nib == PRE_NIBBLE) begin
                        state_d = ST_PRE;
                    end else if (nib == SFD_NIBBLE) begin
                        state_d   = ST_LO;
                        rxd_d     = SFD_BYTE;
                        rxdv_d    = 1'b1;
                        sof_d     = 1'b1;
                        cnt_start = 1'b1;
                    end else begin
                        state_d   = ST_DROP;
                        pre_err_d = 1'b1;
                    end
                end
                ST_LO: begin
                    if (!rx.rxdv_in) begin
                        state_d = ST_EOF;
                        eof_d   = 1'b1;
                        long_d  = cnt_ovf;
                    end else begin
                        state_d  = ST_HI;
                        lat_d    = nib;
                        er_lat_d = rx.rxer_in;
                    end
                end
                ST_HI: begin
                    if (!rx.rxdv_in) begin
                        state_d = ST_EOF;
                        eof_d   = 1'b1;
                        drib_d  = 1'b1;
                        long_d  = cnt_ovf;
                    end else begin
                        state_d = ST_LO;
                        cnt_inc = 1'b1;
                        if (!cnt_full) begin
                            rxd_d  = {nib, lat_q};
                            rxdv_d = 1'b1;
                            rxer_d = er_lat_q | rx.rxer_in;
                        end
                    end
                end
                ST_DROP: begin
                    if (!rx.rxdv_in) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, nibble latch and registered outputs.
    always_ff @(posedge clk_gmii_2x or negedge resetn_rx) begin
        if (!resetn_rx) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            er_lat_q  <= 1'b0;
            rxd_q     <= '0;
            rxdv_q    <= 1'b0;
            rxer_q    <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            drib_q    <= 1'b0;
            long_q    <= 1'b0;
            pre_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            er_lat_q  <= er_lat_d;
            rxd_q     <= rxd_d;
            rxdv_q    <= rxdv_d;
            rxer_q    <= rxer_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            drib_q    <= drib_d;
            long_q    <= long_d;
            pre_err_q <= pre_err_d;
        end
    end

    assign rx.rxd_out     = rxd_q;
    assign rx.rxdv_out    = rxdv_q;
    assign rx.rxer_out    = rxer_q;
    assign rx.sof_out     = sof_q;
    assign rx.eof_out     = eof_q;
    assign rx.frame_len   = cnt;
    assign rx.dribble_err = drib_q;
    assign rx.long_err    = long_q;
    assign rx.pre_err     = pre_err_q;
endmodule
